stream_seq_checker: RTL

STREAM_SEQ_CHECKER -- requirements
Module: stream_seq_checker

---
 rtl/stream_dbg_pkg.sv | 19 +
 rtl/stream_throttle.sv | 24 ++
 rtl/stream_seq_checker.sv | 127 ++++++++++++
 3 files changed

// File: rtl/stream_dbg_pkg.sv
// Shared definitions for the stream debug blocks (checker and matching generator).
// Holds the checker state encoding, the throttle phase width and the ready compare.
package stream_dbg_pkg;

    localparam int unsigned PHASE_W = 4;
    localparam int unsigned DUTY_W  = PHASE_W + 1;

    typedef enum logic [0:0] {
        ST_HUNT  = 1'b0,
        ST_TRACK = 1'b1
    } chk_state_t;

    // A phase slot is a ready slot when it falls below the programmed duty.
    function automatic logic phase_is_ready(input logic [PHASE_W-1:0] phase,
                                            input logic [DUTY_W-1:0]  duty);
        return {1'b0, phase} < duty;
    endfunction

endpackage

// File: rtl/stream_throttle.sv
// Ready throttle: free-running phase counter and a registered duty compare.
// Gives ready_duty ready cycles in every 16-cycle window.
module stream_throttle
    import stream_dbg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] ready_duty,
    output logic              ready
);

    logic [PHASE_W-1:0] phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            ready <= 1'b0;
        end else begin
            phase <= phase + PHASE_W'(1);
            ready <= phase_is_ready(phase, ready_duty);
        end
    end

endmodule

// File: rtl/stream_seq_checker.sv
// Incrementing-sequence checker: locks onto the first accepted word, then
// counts accepted words and sequence mismatches, remembering the last bad word.
module stream_seq_checker
    import stream_dbg_pkg::*;
#(
    parameter int unsigned DAT_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned ERR_WIDTH = 16
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [DUTY_W-1:0]    ready_duty,
    input  logic                 din_valid,
    input  logic [DAT_WIDTH-1:0] din,
    output logic                 din_ready,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [DAT_WIDTH-1:0] last_bad
);

    logic [1:0]           rst_sync_q;
    logic                 rst_sync_n;
    logic                 accept_c;
    logic                 mismatch_c;
    logic [DAT_WIDTH-1:0] din_inc;

    chk_state_t           state_q;
    chk_state_t           state_d;
    logic [DAT_WIDTH-1:0] expected_q;
    logic [DAT_WIDTH-1:0] expected_d;
    logic                 locked_d;
    logic                 err_pulse_d;
    logic [CNT_WIDTH-1:0] word_count_d;
    logic [ERR_WIDTH-1:0] err_count_d;
    logic [DAT_WIDTH-1:0] last_bad_d;

    // Reset asserts asynchronously and releases two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    stream_throttle u_throttle (
        .clk        (clk),
        .rst_n      (rst_sync_n),
        .ready_duty (ready_duty),
        .ready      (din_ready)
    );

    assign accept_c   = din_valid & din_ready;
    assign din_inc    = din + DAT_WIDTH'(1);
    assign mismatch_c = (state_q == ST_TRACK) && (din != expected_q);

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_HUNT;
        end else if (accept_c && (state_q == ST_HUNT)) begin
            state_d = ST_TRACK;
        end
    end

    // Clear outranks an accept: the word in that cycle is dropped uncounted.
    always_comb begin
        expected_d   = expected_q;
        locked_d     = locked;
        err_pulse_d  = 1'b0;
        word_count_d = word_count;
        err_count_d  = err_count;
        last_bad_d   = last_bad;
        if (clear) begin
            locked_d     = 1'b0;
            word_count_d = '0;
            err_count_d  = '0;
            last_bad_d   = '0;
        end else if (accept_c) begin
            expected_d = din_inc;
            locked_d   = 1'b1;
            if (word_count != '1) begin
                word_count_d = word_count + CNT_WIDTH'(1);
            end
            if (mismatch_c) begin
                err_pulse_d = 1'b1;
                last_bad_d  = din;
                if (err_count != '1) begin
                    err_count_d = err_count + ERR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            expected_q <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            word_count <= '0;
            err_count  <= '0;
            last_bad   <= '0;
        end else begin
            expected_q <= expected_d;
            locked     <= locked_d;
            err_pulse  <= err_pulse_d;
            word_count <= word_count_d;
            err_count  <= err_count_d;
            last_bad   <= last_bad_d;
        end
    end

endmodule
